// File: rtl/mem_responder.sv
// mem_responder: word-array memory responder with programmable wait states
// and a 4-phase dataIsPresent handshake. Outputs are registered. Out-of-range
// addresses are flagged on err and never touch the array.
module mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rnw,
  input  logic [14:0] addrMem,
  input  logic [15:0] wordIn,
  output logic [15:0] wordOut,
  output logic        dataIsPresent,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // RELEASE is folded into RESP: holding RESP until enable drops is the release phase.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rnw_q, rnw_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic [15:0] wordOut_q, wordOut_d;
  logic        dip_q, dip_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  // Access-side view of the request: straight from the inputs when RESP is
  // entered directly from IDLE, otherwise from the captured registers.
  logic                 acc_en_s;
  logic                 acc_rnw_s;
  logic [14:0]          acc_addr_s;
  logic [15:0]          acc_wdata_s;
  logic                 in_range_s;
  logic [ADDR_BITS-1:0] mem_idx_s;

  logic [15:0] mem_q [0:DEPTH-1];

  // Next-state logic and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          rnw_d   = rnw;
          addr_d  = addrMem;
          wdata_d = wordIn;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (enable) begin
          state_d = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Select the request fields used on the access edge and decode the address.
  always_comb begin
    acc_en_s = 1'b0;
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      acc_en_s = 1'b1;
    end else begin
      acc_en_s = 1'b0;
    end
    if (state_q == S_IDLE) begin
      acc_rnw_s   = rnw;
      acc_addr_s  = addrMem;
      acc_wdata_s = wordIn;
    end else begin
      acc_rnw_s   = rnw_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
    in_range_s = ((acc_addr_s >> ADDR_BITS) == 15'd0);
    mem_idx_s  = acc_addr_s[ADDR_BITS-1:0];
  end

  // Output next values; read data is taken on the edge that enters RESP.
  always_comb begin
    wordOut_d = wordOut_q;
    if (acc_en_s && acc_rnw_s) begin
      if (in_range_s) begin
        wordOut_d = mem_q[mem_idx_s];
      end else begin
        wordOut_d = 16'h0000;
      end
    end else begin
      wordOut_d = wordOut_q;
    end
    dip_d  = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
    err_d  = (state_d == S_RESP) && !in_range_s;
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rnw_q     <= 1'b1;
      addr_q    <= 15'd0;
      wdata_q   <= 16'h0000;
      wordOut_q <= 16'h0000;
      dip_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wordOut_q <= wordOut_d;
      dip_q     <= dip_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Array write on RESP entry; reset blocks the commit, contents are kept.
  always_ff @(posedge clk) begin
    if (!reset && acc_en_s && !acc_rnw_s && in_range_s) begin
      mem_q[mem_idx_s] <= acc_wdata_s;
    end
  end

  assign wordOut       = wordOut_q;
  assign dataIsPresent = dip_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance A uses WAIT_STATES=2, instance B
// uses WAIT_STATES=0; both use ADDR_BITS=10.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en_a, rnw_a, dip_a, busy_a, err_a;
  logic [14:0] addr_a;
  logic [15:0] word_a, wo_a;
  logic        en_b, rnw_b, dip_b, busy_b, err_b;
  logic [14:0] addr_b;
  logic [15:0] word_b, wo_b;

  mem_responder #(.ADDR_BITS(10), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .rnw(rnw_a), .addrMem(addr_a),
    .wordIn(word_a), .wordOut(wo_a), .dataIsPresent(dip_a), .busy(busy_a), .err(err_a)
  );

  mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .rnw(rnw_b), .addrMem(addr_b),
    .wordIn(word_b), .wordOut(wo_b), .dataIsPresent(dip_b), .busy(busy_b), .err(err_b)
  );

  // sel chooses which instance the transaction task talks to.
  logic        sel;
  logic [15:0] wo_m;
  logic        dip_m, busy_m, err_m;
  assign wo_m   = sel ? wo_b   : wo_a;
  assign dip_m  = sel ? dip_b  : dip_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign err_m  = sel ? err_b  : err_a;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic r, input logic [14:0] a, input logic [15:0] d);
    if (sel) begin
      en_b = en; rnw_b = r; addr_b = a; word_b = d;
    end else begin
      en_a = en; rnw_a = r; addr_a = a; word_a = d;
    end
  endtask

  // One complete handshake: request, wait for dataIsPresent, optional extra
  // hold cycles with enable high, then release and check the return to idle.
  task automatic xact(input string tag, input logic r, input logic [14:0] a,
                      input logic [15:0] d, input int hold, input bit scr,
                      input logic [15:0] exp_wo, input logic exp_err);
    int n;
    logic rr;
    logic [14:0] aa;
    logic [15:0] dd;
    rr = r; aa = a; dd = d;
    @(negedge clk);
    drive(1'b1, rr, aa, dd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!dip_m && scr) begin
        rr = ~rr; aa = aa ^ 15'h7fff; dd = ~dd;
        drive(1'b1, rr, aa, dd);
      end
    end while (!dip_m && n < 20);
    check({tag, "_lat"}, n, sel ? 32'd1 : 32'd3);
    check({tag, "_wo"}, {16'h0, wo_m}, {16'h0, exp_wo});
    check({tag, "_err"}, {31'h0, err_m}, {31'h0, exp_err});
    check({tag, "_busy"}, {31'h0, busy_m}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_dip"}, {31'h0, dip_m}, 32'd1);
      check({tag, "_hold_wo"}, {16'h0, wo_m}, {16'h0, exp_wo});
    end
    drive(1'b0, rr, aa, dd);
    @(negedge clk);
    check({tag, "_rel_dip"}, {31'h0, dip_m}, 32'd0);
    check({tag, "_rel_busy"}, {31'h0, busy_m}, 32'd0);
    check({tag, "_rel_err"}, {31'h0, err_m}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sel   = 1'b0;
    en_a = 1'b0; rnw_a = 1'b0; addr_a = 15'h0; word_a = 16'h0;
    en_b = 1'b0; rnw_b = 1'b0; addr_b = 15'h0; word_b = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_wo_a", {16'h0, wo_a}, 32'h0);
    check("rst_dip_a", {31'h0, dip_a}, 32'd0);
    check("rst_busy_a", {31'h0, busy_a}, 32'd0);
    check("rst_err_a", {31'h0, err_a}, 32'd0);
    check("rst_wo_b", {16'h0, wo_b}, 32'h0);
    check("rst_dip_b", {31'h0, dip_b}, 32'd0);
    reset = 1'b0;

    // Basic write then read back.
    xact("wr5",   1'b0, 15'h0005, 16'hBEEF, 0, 1'b0, 16'hBEEF ^ 16'hBEEF, 1'b0);
    xact("rd5",   1'b1, 15'h0005, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0);

    // Out-of-range access and no aliasing onto address 0.
    xact("wr0",   1'b0, 15'h0000, 16'h1111, 0, 1'b0, 16'hBEEF, 1'b0);
    xact("wr400", 1'b0, 15'h0400, 16'h1234, 0, 1'b0, 16'hBEEF, 1'b1);
    xact("rd0",   1'b1, 15'h0000, 16'h0000, 0, 1'b0, 16'h1111, 1'b0);
    xact("rd400", 1'b1, 15'h0400, 16'h0000, 0, 1'b0, 16'h0000, 1'b1);

    // Enable held 5 cycles past dataIsPresent: no second access.
    xact("wrhold", 1'b0, 15'h0005, 16'hCAFE, 5, 1'b0, 16'h0000, 1'b0);
    xact("rdhold", 1'b1, 15'h0005, 16'h0000, 5, 1'b0, 16'hCAFE, 1'b0);

    // Enable dropped during WAIT: completes, RESP lasts one cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 15'h0005, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 15'h0005, 16'h0000);
    n = 1;
    while (!dip_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("viol_lat", n, 32'd3);
    check("viol_wo", {16'h0, wo_a}, {16'h0, 16'hCAFE});
    @(negedge clk);
    check("viol_dip", {31'h0, dip_a}, 32'd0);
    check("viol_busy", {31'h0, busy_a}, 32'd0);

    // Reset during WAIT discards the pending write.
    xact("wr10", 1'b0, 15'h0010, 16'h5555, 0, 1'b0, 16'hCAFE, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 15'h0010, 16'hAAAA);
    @(negedge clk);
    check("abort_busy_pre", {31'h0, busy_a}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_wo", {16'h0, wo_a}, 32'h0);
    check("abort_dip", {31'h0, dip_a}, 32'd0);
    check("abort_busy", {31'h0, busy_a}, 32'd0);
    check("abort_err", {31'h0, err_a}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 15'h0000, 16'h0000);
    xact("rd10", 1'b1, 15'h0010, 16'h0000, 0, 1'b0, 16'h5555, 1'b0);

    // Inputs scrambled during WAIT: captured values win.
    xact("wrscr", 1'b0, 15'h0020, 16'h1357, 0, 1'b1, 16'h5555, 1'b0);
    xact("rdscr", 1'b1, 15'h0020, 16'h0000, 0, 1'b1, 16'h1357, 1'b0);

    // Zero wait states, back-to-back requests with one-cycle gaps.
    sel = 1'b1;
    xact("b_wr1", 1'b0, 15'h0001, 16'h0101, 0, 1'b0, 16'h0000, 1'b0);
    xact("b_wr2", 1'b0, 15'h0002, 16'h0202, 0, 1'b0, 16'h0000, 1'b0);
    xact("b_rd1", 1'b1, 15'h0001, 16'h0000, 0, 1'b0, 16'h0101, 1'b0);
    xact("b_rd2", 1'b1, 15'h0002, 16'h0000, 0, 1'b0, 16'h0202, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's memory bus.
- Accepts read and write requests issued by the memory manager over a 15-bit address and 16-bit word bus.
- Serves requests from an internal synchronous word array after a programmable number of wait states.
- Signals completion on dataIsPresent using a 4-phase level handshake. Used as the main-memory model and, synthesised, as on-chip RAM.

Parameters:
- ADDR_BITS, 10, implemented address bits. Array holds 2**ADDR_BITS 16-bit words. Legal range 1..15.
- WAIT_STATES, 2, extra cycles between request acceptance and response. Legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  request valid; held high by the manager until dataIsPresent is seen, then dropped.
- rnw  input  1  1 = read, 0 = write; sampled with the request.
- addrMem  input  15  word address; sampled with the request.
- wordIn  input  16  write data from the manager; sampled with the request.
- wordOut  output  16  read data to the manager.
- dataIsPresent  output  1  response valid / acknowledge for reads and writes.
- busy  output  1  high whenever the FSM is not in IDLE.
- err  output  1  out-of-range address flag; valid while dataIsPresent = 1.

Behaviour:
- Reset (reset = 1 at an edge):
  - state = IDLE, wordOut = 16'h0000, dataIsPresent = 0, busy = 0, err = 0, wait counter = 0.
  - Array contents are not cleared.
  - Reset dominates all other inputs.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM has four states, IDLE, WAIT, RESP and RELEASE:
  - IDLE: if enable = 1, capture addrMem, rnw and wordIn into internal registers. If WAIT_STATES = 0, go to RESP; otherwise load counter = WAIT_STATES and go to WAIT.
  - WAIT: decrement counter each cycle. When counter = 1, go to RESP. Inputs are ignored; captured values are used.
  - RESP: dataIsPresent = 1. Stay while enable = 1. When enable = 0, go to IDLE.
  - RELEASE: not used; the RESP hold provides the release phase. An implementation may merge it, but behaviour must match the RESP description.
- Latency: if enable is first high in cycle c while in IDLE, dataIsPresent is first high in cycle c+1+WAIT_STATES.
- Access point: the array read or write occurs on the edge that enters RESP.
  - Read: wordOut = array[captured addr] from the first RESP cycle. It stays stable through RESP and holds its last value afterwards, until the next read.
  - Write: array[captured addr] = captured wordIn. wordOut is unchanged.
- Out of range: captured addr >= 2**ADDR_BITS.
  - Read: wordOut = 16'h0000.
  - Write: the array is not modified.
  - err = 1 together with dataIsPresent; err = 0 in all other states.
- Addresses below 2**ADDR_BITS use the low ADDR_BITS bits directly. Upper bits must be zero, so there is no aliasing.
- Handshake rules:
  - A new request is accepted only in IDLE.
  - The enable level still high from a completed transaction cannot restart a request, because the FSM stays in RESP until enable drops.
  - Minimum turnaround: enable low for 1 cycle before IDLE samples the next request.
- If enable drops during WAIT (protocol violation), the transaction still completes. RESP is then held for exactly one cycle, because enable is already low.
- Changes on rnw, addrMem or wordIn after acceptance have no effect.
- Reset during WAIT or RESP:
  - The transaction is aborted and a pending write is discarded.
  - A write that already entered RESP has already committed.

Test Plan:
- WAIT_STATES = 2: write addr 0x0005 data 0xBEEF with enable in cycle 10, dataIsPresent in cycle 13, enable dropped in cycle 14. Then read addr 0x0005 -> dataIsPresent 3 cycles after acceptance, wordOut = 0xBEEF, err = 0.
- ADDR_BITS = 10: read addr 0x0400 -> wordOut = 0x0000, err = 1 with dataIsPresent. Write 0x1234 to 0x0400, then read 0x0000 -> no aliasing; location 0x0000 keeps its prior value.
- Manager holds enable high 5 cycles after dataIsPresent rises -> dataIsPresent stays high for all 5 cycles. No second access occurs (array and wordOut unchanged). busy falls one cycle after enable drops.
- Reset asserted during WAIT of a write to 0x0010 with data 0xAAAA -> next cycle all outputs are at reset values. A later read of 0x0010 returns the old contents, not 0xAAAA.
- WAIT_STATES = 0: back-to-back read requests with a 1-cycle enable gap -> each dataIsPresent rises 1 cycle after acceptance. wordOut matches each address.
- addrMem, rnw and wordIn toggled every cycle during WAIT -> response uses the values captured at acceptance only.
